// File: rtl/cmplx_mult_seq.sv
// Sequenced complex multiplier: (ar + j*ai) * (br + j*bi), or the product with conj(b).
// Four partial products go through one shared external multiplier, one per cycle.
module cmplx_mult_seq #(
  parameter int WIDTH = 16,
  parameter int OW    = 2*WIDTH+1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_conj,
  input  logic signed [WIDTH-1:0]   in_ar,
  input  logic signed [WIDTH-1:0]   in_ai,
  input  logic signed [WIDTH-1:0]   in_br,
  input  logic signed [WIDTH-1:0]   in_bi,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OW-1:0]      out_re,
  output logic signed [OW-1:0]      out_im,
  output logic signed [WIDTH-1:0]   mul_a,
  output logic signed [WIDTH-1:0]   mul_b,
  input  logic signed [2*WIDTH-1:0] mul_p,
  output logic                      busy
);

  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, DONE} state_t;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_ar, r_ai, r_br, r_bi;
  logic                    r_conj;
  logic signed [OW-1:0]    r_acc_re, r_acc_im;
  logic signed [OW-1:0]    w_p;

  assign w_p = OW'(mul_p);

  // mul_a/mul_b are registered one step ahead so the product is ready
  // for capture in the cycle the step is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      r_ar      <= '0;
      r_ai      <= '0;
      r_br      <= '0;
      r_bi      <= '0;
      r_conj    <= 1'b0;
      r_acc_re  <= '0;
      r_acc_im  <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_ar     <= in_ar;
          r_ai     <= in_ai;
          r_br     <= in_br;
          r_bi     <= in_bi;
          r_conj   <= in_conj;
          mul_a    <= in_ar;
          mul_b    <= in_br;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          r_state  <= M0;
        end
        M0: begin
          r_acc_re <= w_p;
          mul_a    <= r_ai;
          mul_b    <= r_bi;
          r_state  <= M1;
        end
        M1: begin
          r_acc_re <= r_conj ? r_acc_re + w_p : r_acc_re - w_p;
          mul_a    <= r_ar;
          mul_b    <= r_bi;
          r_state  <= M2;
        end
        M2: begin
          r_acc_im <= r_conj ? -w_p : w_p;
          mul_a    <= r_ai;
          mul_b    <= r_br;
          r_state  <= M3;
        end
        M3: begin
          out_re    <= r_acc_re;
          out_im    <= r_acc_im + w_p;
          mul_a     <= '0;
          mul_b     <= '0;
          out_valid <= 1'b1;
          r_state   <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmplx_mult_seq.sv
// Directed + random bench for cmplx_mult_seq against a plain-arithmetic complex product model.
module tb_cmplx_mult_seq;
  localparam int WIDTH = 16;
  localparam int OW    = 2*WIDTH+1;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic                      in_conj = 1'b0;
  logic signed [WIDTH-1:0]   in_ar = '0, in_ai = '0, in_br = '0, in_bi = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic signed [OW-1:0]      out_re, out_im;
  logic signed [WIDTH-1:0]   mul_a, mul_b;
  logic signed [2*WIDTH-1:0] mul_p;
  logic                      busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = -100;
  bit chk_gap = 1'b0;

  // Stand-in for the external combinational signed multiplier.
  assign mul_p = mul_a * mul_b;

  cmplx_mult_seq #(.WIDTH(WIDTH), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_conj(in_conj),
    .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic signed [WIDTH-1:0] ar, ai, br, bi,
                        input logic cj, input int hold, input bit churn);
    longint ere, eim, lre, lim;
    longint ea[4], eb[4];
    int t;
    ere = cj ? longint'(ar)*longint'(br) + longint'(ai)*longint'(bi)
             : longint'(ar)*longint'(br) - longint'(ai)*longint'(bi);
    eim = cj ? longint'(ai)*longint'(br) - longint'(ar)*longint'(bi)
             : longint'(ar)*longint'(bi) + longint'(ai)*longint'(br);
    ea = '{longint'(ar), longint'(ai), longint'(ar), longint'(ai)};
    eb = '{longint'(br), longint'(bi), longint'(bi), longint'(br)};
    in_ar = ar; in_ai = ai; in_br = br; in_bi = bi; in_conj = cj;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) chk("accept_timeout", 1, 0);
    @(posedge clk);
    if (chk_gap) chk("throughput_gap", cyc - last_acc, 6);
    last_acc = cyc;
    #1;
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("mul_a_step%0d", s), longint'(mul_a), ea[s]);
      chk($sformatf("mul_b_step%0d", s), longint'(mul_b), eb[s]);
      chk("valid_low_in_step", longint'(out_valid), 0);
      chk("ready_low_in_step", longint'(in_ready), 0);
      chk("busy_in_step", longint'(busy), 1);
      if (churn) begin
        in_ar = WIDTH'($urandom); in_ai = WIDTH'($urandom);
        in_br = WIDTH'($urandom); in_bi = WIDTH'($urandom);
        in_conj = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    chk("valid_after_4", longint'(out_valid), 1);
    chk("out_re", longint'(out_re), ere);
    chk("out_im", longint'(out_im), eim);
    chk("mul_a_done", longint'(mul_a), 0);
    lre = longint'(out_re); lim = longint'(out_im);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_re_stable", longint'(out_re), lre);
      chk("bp_im_stable", longint'(out_im), lim);
      chk("bp_in_ready", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_dropped", longint'(out_valid), 0);
    chk("in_ready_back", longint'(in_ready), 1);
    chk("busy_cleared", longint'(busy), 0);
    chk("re_held", longint'(out_re), ere);
    chk("im_held", longint'(out_im), eim);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_out_re", longint'(out_re), 0);
    chk("rst_mul_a", longint'(mul_a), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Basic, conjugate, extremes
    run_op(16'sd3, 16'sd4, 16'sd5, 16'sd6, 1'b0, 0, 1'b0);
    chk("basic_re_const", longint'(out_re), -9);
    chk("basic_im_const", longint'(out_im), 38);
    run_op(16'sd3, 16'sd4, 16'sd5, 16'sd6, 1'b1, 0, 1'b0);
    chk("conj_re_const", longint'(out_re), 39);
    chk("conj_im_const", longint'(out_im), 2);
    run_op(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 1'b0, 0, 1'b0);
    chk("ext1_im_const", longint'(out_im), 64'sd2147483648);
    run_op(-16'sd32768, -16'sd32768, -16'sd32768, 16'sd32767, 1'b0, 0, 1'b0);
    chk("ext2_re_const", longint'(out_re), 64'sd2147450880);
    chk("ext2_im_const", longint'(out_im), 32768);
    run_op(-16'sd32768, 16'sd32767, -16'sd32768, 16'sd32767, 1'b1, 0, 1'b0);

    // Backpressure
    run_op(16'sd1234, -16'sd777, 16'sd42, 16'sd9, 1'b1, 10, 1'b0);

    // Back-to-back throughput
    chk_gap = 1'b0;
    run_op(16'sd11, 16'sd22, 16'sd33, 16'sd44, 1'b0, 0, 1'b0);
    chk_gap = 1'b1;
    run_op(-16'sd5, 16'sd7, 16'sd100, -16'sd3, 1'b1, 0, 1'b0);
    run_op(16'sd9, -16'sd9, 16'sd9, -16'sd9, 1'b0, 0, 1'b0);
    chk_gap = 1'b0;

    // Random operands with input churn
    for (int i = 0; i < 8; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
             1'($urandom), (i == 3) ? 3 : 0, 1'b1);

    // Reset during M2
    in_ar = 16'sd100; in_ai = 16'sd200; in_br = 16'sd300; in_bi = 16'sd400; in_conj = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("m2_mul_a", longint'(mul_a), 100);
    chk("m2_mul_b", longint'(mul_b), 400);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", longint'(out_valid), 0);
    chk("async_rst_ready", longint'(in_ready), 1);
    chk("async_rst_busy", longint'(busy), 0);
    chk("async_rst_mul_a", longint'(mul_a), 0);
    chk("async_rst_mul_b", longint'(mul_b), 0);
    chk("async_rst_re", longint'(out_re), 0);
    chk("async_rst_im", longint'(out_im), 0);

    // in_valid held high across reset release: accepted on the first live edge
    in_ar = 16'sd1; in_ai = 16'sd1; in_br = 16'sd1; in_bi = -16'sd1; in_conj = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("no_stale_valid", longint'(out_valid), 0);
    run_op(16'sd1, 16'sd1, 16'sd1, -16'sd1, 1'b0, 0, 1'b0);
    chk("post_rst_re_const", longint'(out_re), 2);
    chk("post_rst_im_const", longint'(out_im), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
